// File: rtl/fwd_scoreboard.sv
// Stateful operand-forwarding scoreboard: tracks in-flight register writes per
// pipeline stage, picks the youngest producer per source and flags load hazards.
module fwd_scoreboard #(
    parameter int DATA_W     = 16,
    parameter int REG_W      = 3,
    parameter int NUM_SRC    = 2,
    parameter int DEPTH      = 3,
    parameter int SEL_W      = 2,
    parameter int LOAD_STAGE = 1,
    parameter int CNT_W      = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       advance,
    input  logic                       flush,
    input  logic                       iss_valid,
    input  logic                       iss_wr,
    input  logic                       iss_load,
    input  logic [REG_W-1:0]           iss_dest,
    input  logic [NUM_SRC-1:0]         src_used,
    input  logic [NUM_SRC*REG_W-1:0]   src_reg,
    input  logic [DEPTH*DATA_W-1:0]    stage_data,
    input  logic                       mem_done,
    output logic [NUM_SRC*SEL_W-1:0]   fwd_sel,
    output logic [NUM_SRC*DATA_W-1:0]  fwd_data,
    output logic                       stall,
    output logic [CNT_W-1:0]           stall_cnt
);

    logic [DEPTH-1:0] ent_vld;
    logic [DEPTH-1:0] ent_wr;
    logic [DEPTH-1:0] ent_load;
    logic [REG_W-1:0] ent_dest [DEPTH];

    logic [SEL_W-1:0]  sel_c;
    logic [DATA_W-1:0] dat_c;
    logic              haz_c;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Per-source youngest-match search: scanning oldest to youngest lets the
    // youngest hit overwrite any older one.
    always_comb begin
        fwd_sel  = '0;
        fwd_data = '0;
        stall    = 1'b0;
        sel_c    = '0;
        dat_c    = '0;
        haz_c    = 1'b0;
        for (int s = 0; s < NUM_SRC; s++) begin
            sel_c = '0;
            dat_c = '0;
            haz_c = 1'b0;
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (src_used[s] && ent_vld[k] && ent_wr[k] &&
                    (ent_dest[k] == src_reg[s*REG_W +: REG_W])) begin
                    sel_c = SEL_W'(k + 1);
                    dat_c = stage_data[k*DATA_W +: DATA_W];
                    haz_c = ent_load[k] &&
                            ((k < LOAD_STAGE) || ((k == LOAD_STAGE) && !mem_done));
                end
            end
            if (haz_c) begin
                stall = 1'b1;
            end else begin
                fwd_sel[s*SEL_W +: SEL_W]    = sel_c;
                fwd_data[s*DATA_W +: DATA_W] = dat_c;
            end
        end
    end

    // Shift scoreboard; a stalled or flushed issue slot enters EX as a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_vld   <= '0;
            ent_wr    <= '0;
            ent_load  <= '0;
            stall_cnt <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                ent_dest[k] <= '0;
            end
        end else if (advance) begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                ent_vld[k]  <= ent_vld[k-1];
                ent_wr[k]   <= ent_wr[k-1];
                ent_load[k] <= ent_load[k-1];
                ent_dest[k] <= ent_dest[k-1];
            end
            ent_vld[0]  <= iss_valid & ~flush & ~stall;
            ent_wr[0]   <= iss_wr;
            ent_load[0] <= iss_load;
            ent_dest[0] <= iss_dest;
            if (stall) begin
                stall_cnt <= sat_inc(stall_cnt);
            end
        end
    end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard: forwarding priority, load-use stalls,
// flush, global hold and asynchronous reset.
module tb_fwd_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        advance;
    logic        flush;
    logic        iss_valid;
    logic        iss_wr;
    logic        iss_load;
    logic [2:0]  iss_dest;
    logic [1:0]  src_used;
    logic [5:0]  src_reg;
    logic [47:0] stage_data;
    logic        mem_done;
    logic [3:0]  fwd_sel;
    logic [31:0] fwd_data;
    logic        stall;
    logic [7:0]  stall_cnt;

    int errors = 0;
    int checks = 0;

    fwd_scoreboard dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .advance    (advance),
        .flush      (flush),
        .iss_valid  (iss_valid),
        .iss_wr     (iss_wr),
        .iss_load   (iss_load),
        .iss_dest   (iss_dest),
        .src_used   (src_used),
        .src_reg    (src_reg),
        .stage_data (stage_data),
        .mem_done   (mem_done),
        .fwd_sel    (fwd_sel),
        .fwd_data   (fwd_data),
        .stall      (stall),
        .stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input logic v, input logic w, input logic ld, input logic [2:0] d);
        iss_valid = v;
        iss_wr    = w;
        iss_load  = ld;
        iss_dest  = d;
    endtask

    task automatic drain();
        src_used = 2'b00;
        issue(1'b0, 1'b0, 1'b0, 3'd0);
        repeat (3) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; advance = 1'b1; flush = 1'b0; mem_done = 1'b0;
        issue(1'b0, 1'b0, 1'b0, 3'd0);
        src_used = 2'b00; src_reg = '0; stage_data = '0;
        #12;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_sel", 32'(fwd_sel), 32'd0);
        chk("rst_data", fwd_data, 32'd0);
        chk("rst_cnt", 32'(stall_cnt), 32'd0);
        rst_n = 1'b1;
        tick();

        // ALU chain: r3 produced in EX, consumed next cycle
        issue(1'b1, 1'b1, 1'b0, 3'd3);
        tick();
        issue(1'b0, 1'b0, 1'b0, 3'd0);
        src_used = 2'b01; src_reg = {3'd0, 3'd3};
        stage_data = {16'h0000, 16'h0000, 16'h1234};
        #1;
        chk("alu_sel0", 32'(fwd_sel[1:0]), 32'd1);
        chk("alu_data0", 32'(fwd_data[15:0]), 32'h1234);
        chk("alu_stall", 32'(stall), 32'd0);
        drain();

        // Youngest wins: r2 in entries 0 and 2, r7 in entry 1
        issue(1'b1, 1'b1, 1'b0, 3'd2); tick();
        issue(1'b1, 1'b1, 1'b0, 3'd7); tick();
        issue(1'b1, 1'b1, 1'b0, 3'd2); tick();
        issue(1'b0, 1'b0, 1'b0, 3'd0);
        src_used = 2'b10; src_reg = {3'd2, 3'd7};
        stage_data = {16'h5555, 16'h7777, 16'hAAAA};
        #1;
        chk("young_sel1", 32'(fwd_sel[3:2]), 32'd1);
        chk("young_data1", 32'(fwd_data[31:16]), 32'hAAAA);
        chk("young_sel0_unused", 32'(fwd_sel[1:0]), 32'd0);
        src_used = 2'b11;
        #1;
        chk("mem_sel0", 32'(fwd_sel[1:0]), 32'd2);
        chk("mem_data0", 32'(fwd_data[15:0]), 32'h7777);
        chk("young_stall", 32'(stall), 32'd0);
        drain();

        // Load-use: load r4, consumer stalls until mem_done in stage 1
        issue(1'b1, 1'b1, 1'b1, 3'd4); tick();
        issue(1'b0, 1'b0, 1'b0, 3'd0);
        src_used = 2'b01; src_reg = {3'd0, 3'd4};
        stage_data = {16'h0000, 16'hBEEF, 16'h0000};
        #1;
        chk("lu_stall_ex", 32'(stall), 32'd1);
        chk("lu_cnt0", 32'(stall_cnt), 32'd0);
        tick();
        chk("lu_cnt1", 32'(stall_cnt), 32'd1);
        chk("lu_stall_mem_wait", 32'(stall), 32'd1);
        mem_done = 1'b1;
        #1;
        chk("lu_stall_done", 32'(stall), 32'd0);
        chk("lu_sel_done", 32'(fwd_sel[1:0]), 32'd2);
        chk("lu_data_done", 32'(fwd_data[15:0]), 32'hBEEF);

        // Global hold with the load still waiting in stage 1
        mem_done = 1'b0; advance = 1'b0;
        repeat (5) tick();
        chk("hold_cnt", 32'(stall_cnt), 32'd1);
        chk("hold_stall", 32'(stall), 32'd1);
        advance = 1'b1;
        tick();
        chk("lu_cnt2", 32'(stall_cnt), 32'd2);
        stage_data = {16'hC0DE, 16'h0000, 16'h0000};
        #1;
        chk("wb_stall", 32'(stall), 32'd0);
        chk("wb_sel", 32'(fwd_sel[1:0]), 32'd3);
        chk("wb_data", 32'(fwd_data[15:0]), 32'hC0DE);
        drain();

        // Unused source and non-writing producer never forward
        issue(1'b1, 1'b0, 1'b0, 3'd1); tick();
        issue(1'b1, 1'b1, 1'b0, 3'd6); tick();
        issue(1'b0, 1'b0, 1'b0, 3'd0);
        src_used = 2'b10; src_reg = {3'd1, 3'd6};
        stage_data = {16'h1111, 16'h2222, 16'h3333};
        #1;
        chk("nouse_sel", 32'(fwd_sel), 32'd0);
        chk("nouse_data", fwd_data, 32'd0);
        chk("nouse_stall", 32'(stall), 32'd0);
        drain();

        // Flushed producer becomes a bubble
        issue(1'b1, 1'b1, 1'b0, 3'd5); flush = 1'b1; tick();
        issue(1'b0, 1'b0, 1'b0, 3'd0); flush = 1'b0;
        src_used = 2'b01; src_reg = {3'd0, 3'd5};
        #1;
        chk("flush_sel", 32'(fwd_sel[1:0]), 32'd0);
        chk("flush_stall", 32'(stall), 32'd0);
        drain();

        // Asynchronous reset while a load-use stall is pending
        issue(1'b1, 1'b1, 1'b1, 3'd4); tick();
        issue(1'b0, 1'b0, 1'b0, 3'd0);
        src_used = 2'b01; src_reg = {3'd0, 3'd4};
        #1;
        chk("pre_rst_stall", 32'(stall), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_stall", 32'(stall), 32'd0);
        chk("arst_cnt", 32'(stall_cnt), 32'd0);
        chk("arst_sel", 32'(fwd_sel), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fwd_scoreboard.md
Name: fwd_scoreboard

Overview:
- Parametrised, stateful successor to the combinational EX/MEM/WB forwarding logic.
- Tracks every in-flight register write in a DEPTH-entry shift scoreboard (entry 0 = EX, 1 = MEM, 2 = WB, ...).
- For each of NUM_SRC source operands of the instruction in ID/EX, it selects the youngest matching producer.
- It forwards that producer's data and raises a stall for load-use and multi-cycle-memory hazards. It also counts stall cycles for performance monitoring.

Parameters:
- DATA_W, 16, datapath width.
- REG_W, 3, register index width (2^REG_W registers).
- NUM_SRC, 2, source operands checked per cycle.
- DEPTH, 3, pipeline stages tracked after ID (>=2).
- SEL_W, 2, select width; must satisfy 2^SEL_W > DEPTH.
- LOAD_STAGE, 1, stage index at which load data is valid once mem_done is high.
- CNT_W, 8, stall counter width.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- advance  in  1  pipeline advances this cycle (low = global memory stall, all entries hold).
- flush  in  1  squash the instruction entering EX (branch/jump redirect).
- iss_valid  in  1  instruction in ID/EX is real (not a bubble).
- iss_wr  in  1  that instruction writes a register.
- iss_load  in  1  that instruction is a load.
- iss_dest  in  REG_W  its destination register (already RegDst-resolved).
- src_used  in  NUM_SRC  per-source "operand is actually read" (rs/rt used).
- src_reg  in  NUM_SRC*REG_W  source register indices, source 0 in LSBs.
- stage_data  in  DEPTH*DATA_W  write-back value each stage will produce; slot k = stage k.
- mem_done  in  1  load in LOAD_STAGE has its data on stage_data slot LOAD_STAGE.
- fwd_sel  out  NUM_SRC*SEL_W  0 = register file, k+1 = forward from stage k.
- fwd_data  out  NUM_SRC*DATA_W  forwarded value (0 when fwd_sel = 0).
- stall  out  1  hold ID and insert bubble into EX.
- stall_cnt  out  CNT_W  saturating count of stall cycles since reset.

Behaviour:
- Entry fields: vld, wr, load, dest. Reset clears all entries; stall_cnt = 0.
- Outputs are combinational from state and inputs; at reset fwd_sel = 0, fwd_data = 0, stall = 0.
- Shift rule on a clock edge with advance = 1:
  - entry k+1 <= entry k for k = 0..DEPTH-2; entry DEPTH-1 retires.
  - entry 0 <= {iss_valid, iss_wr, iss_load, iss_dest}, except that it becomes a bubble (vld = 0) if flush = 1 or stall = 1.
- advance = 0: all entries hold, including entry 0. flush is ignored when advance = 0; the pipeline must re-assert flush with advance.
- Match for source s, stage k: src_used[s] & vld_k & wr_k & (dest_k == src_reg[s]).
- Priority: lowest k (youngest) wins; older matches are ignored.
- Winning stage k:
  - load_k & k < LOAD_STAGE → hazard (load-use).
  - load_k & k == LOAD_STAGE & ~mem_done → hazard.
  - Otherwise fwd_sel[s] = k+1 and fwd_data[s] = stage_data slot k.
- No match → fwd_sel[s] = 0, fwd_data[s] = 0.
- stall = OR of hazards over all sources. While stall = 1, fwd_sel/fwd_data of the hazarding source are don't-care; the bench checks them only when stall = 0.
- stall_cnt increments on each edge where stall = 1 and advance = 1, and saturates at all-ones. Cycles with advance = 0 are not counted (global memory stall, not a hazard).
- Simultaneous flush & stall: bubble inserted once; no double count issue since stall_cnt still counts the stall cycle.
- Asynchronous reset mid-operation: all entries invalid immediately, and stall drops in the same cycle.
- A producer in the last stage (DEPTH-1) still forwards; it is the WB-to-EX path.

Test Plan:
- ALU chain: issue wr r3 (ALU); next cycle src0 = r3 → fwd_sel[0] = 1, fwd_data = stage_data slot 0 (e.g. 0x1234), stall = 0.
- Youngest wins: r2 written by entries 0 and 2 with stage data 0xAAAA and 0x5555; src1 = r2 → fwd_sel[1] = 1, data 0xAAAA.
- Load-use: load to r4 in entry 0, src0 = r4 → stall = 1. After one advance the load is in entry 1:
  - with mem_done = 0, stall stays 1;
  - with mem_done = 1 and data 0xBEEF, fwd_sel = 2, data 0xBEEF, stall = 0.
  - stall_cnt = 2 after the stalled advancing cycles.
- src_used = 0 with matching dest → fwd_sel = 0, no stall. Same with wr = 0 producer → fwd_sel = 0.
- Flush: issue wr r5 with flush = 1, advance = 1 → entry 0 bubble. Next cycle src = r5 → fwd_sel = 0.
- advance = 0 for 5 cycles with load pending in entry 1 → entries hold and stall_cnt unchanged. Assert rst_n = 0 asynchronously → stall = 0 and stall_cnt = 0 immediately.
